// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: playlist sequencer issuing start/abort/step commands to the 16-LED pattern engine
// ports: clk, rst_n (async, active-low); cfg_we/cfg_addr/cfg_mode/cfg_rep write one of four
//        {mode, repeat} entries; run plays the playlist, pause freezes step ticks;
//        eng_mode/eng_start/eng_abort/step_tick drive the engine, eng_done ends a pass;
//        busy, cur_idx and pass_cnt report progress
module led_seq_ctrl #(
  parameter int TICK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [1:0] cfg_mode,
  input  logic [3:0] cfg_rep,
  input  logic       run,
  input  logic       pause,
  output logic [1:0] eng_mode,
  output logic       eng_start,
  output logic       eng_abort,
  output logic       step_tick,
  input  logic       eng_done,
  output logic       busy,
  output logic [1:0] cur_idx,
  output logic [7:0] pass_cnt
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, NEXT} state_t;
  localparam logic [25:0] T_LAST = 26'(TICK_DIV - 1);
  localparam logic [25:0] T_PRE = 26'(TICK_DIV - 2);
  state_t state, state_n;
  logic [1:0] mode_q [4];
  logic [3:0] rep_q [4];
  logic [3:0] rep_left, rep_left_n;
  logic [2:0] skip_cnt, skip_n;
  logic [25:0] tick_cnt, tick_n;
  logic [1:0] eng_mode_n, cur_idx_n;
  logic [7:0] pass_n;
  logic abort_n, tick_pulse_n, any_rep;
  assign any_rep = |{rep_q[0], rep_q[1], rep_q[2], rep_q[3]};
  assign busy = state != IDLE;
  assign eng_start = state == START;
  always_comb begin
    state_n = state;
    cur_idx_n = cur_idx;
    pass_n = pass_cnt;
    eng_mode_n = eng_mode;
    rep_left_n = rep_left;
    skip_n = skip_cnt;
    tick_n = tick_cnt;
    abort_n = 1'b0;
    tick_pulse_n = 1'b0;
    if (state != IDLE && !run) begin
      state_n = IDLE;
      abort_n = 1'b1;
    end else begin
      case (state)
        IDLE: if (run && any_rep) begin
          state_n = LOAD;
          cur_idx_n = 2'd0;
          pass_n = 8'd0;
          skip_n = 3'd0;
        end
        LOAD: if (rep_q[cur_idx] == 4'd0) begin
          state_n = NEXT;
          skip_n = skip_cnt + 3'd1;
        end else begin
          state_n = START;
          rep_left_n = rep_q[cur_idx];
          eng_mode_n = mode_q[cur_idx];
          skip_n = 3'd0;
        end
        START: begin
          state_n = WAIT;
          tick_n = 26'd0;
        end
        WAIT: if (eng_done) begin
          pass_n = pass_cnt + 8'd1;
          rep_left_n = rep_left - 4'd1;
          state_n = rep_left == 4'd1 ? NEXT : START;
        end else if (!pause) begin
          tick_n = tick_cnt == T_LAST ? 26'd0 : tick_cnt + 26'd1;
          // tick fires on arrival at the last count, so a pause parked there cannot repeat it
          tick_pulse_n = tick_cnt == T_PRE;
        end
        NEXT: begin
          cur_idx_n = cur_idx + 2'd1;
          state_n = skip_cnt == 3'd4 ? IDLE : LOAD;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur_idx <= 2'd0;
      pass_cnt <= 8'd0;
      eng_mode <= 2'd0;
      rep_left <= 4'd0;
      skip_cnt <= 3'd0;
      tick_cnt <= 26'd0;
      eng_abort <= 1'b0;
      step_tick <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        mode_q[i] <= 2'd0;
        rep_q[i] <= 4'd0;
      end
    end else begin
      state <= state_n;
      cur_idx <= cur_idx_n;
      pass_cnt <= pass_n;
      eng_mode <= eng_mode_n;
      rep_left <= rep_left_n;
      skip_cnt <= skip_n;
      tick_cnt <= tick_n;
      eng_abort <= abort_n;
      step_tick <= tick_pulse_n;
      if (cfg_we) begin
        mode_q[cfg_addr] <= cfg_mode;
        rep_q[cfg_addr] <= cfg_rep;
      end
    end
  end
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: self-checking bench for led_seq_ctrl against a behavioural playlist model
module tb_led_seq_ctrl;
  localparam int TD = 50;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0, cfg_mode = 2'd0;
  logic [3:0] cfg_rep = 4'd0;
  logic run = 1'b0, pause = 1'b0, eng_done = 1'b0;
  logic [1:0] eng_mode, cur_idx;
  logic eng_start, eng_abort, step_tick, busy;
  logic [7:0] pass_cnt;
  led_seq_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
    .cfg_rep(cfg_rep), .run(run), .pause(pause), .eng_mode(eng_mode), .eng_start(eng_start),
    .eng_abort(eng_abort), .step_tick(step_tick), .eng_done(eng_done), .busy(busy),
    .cur_idx(cur_idx), .pass_cnt(pass_cnt)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  typedef enum {P_IDLE, P_LOAD, P_START, P_WAIT, P_NEXT} phase_t;
  phase_t ph = P_IDLE;
  int m_mode [4], m_rep [4];
  int m_idx, m_pass, m_left, m_zero, m_adv, m_out_mode;
  bit m_abort, m_tick;
  task automatic m_reset();
    ph = P_IDLE;
    m_idx = 0; m_pass = 0; m_left = 0; m_zero = 0; m_adv = 0; m_out_mode = 0;
    m_abort = 0; m_tick = 0;
    for (int i = 0; i < 4; i++) begin
      m_mode[i] = 0;
      m_rep[i] = 0;
    end
  endtask
  task automatic m_step();
    m_abort = 0;
    m_tick = 0;
    if (ph != P_IDLE && !run) begin
      ph = P_IDLE;
      m_abort = 1;
    end else begin
      case (ph)
        P_IDLE: if (run && (m_rep[0] + m_rep[1] + m_rep[2] + m_rep[3]) > 0) begin
          ph = P_LOAD; m_idx = 0; m_pass = 0; m_zero = 0;
        end
        P_LOAD: if (m_rep[m_idx] == 0) begin
          m_zero++; ph = P_NEXT;
        end else begin
          m_left = m_rep[m_idx]; m_out_mode = m_mode[m_idx]; m_zero = 0; ph = P_START;
        end
        P_START: begin
          m_adv = 0; ph = P_WAIT;
        end
        P_WAIT: if (eng_done) begin
          m_pass = (m_pass + 1) % 256; m_left--; ph = m_left > 0 ? P_START : P_NEXT;
        end else if (!pause) begin
          m_adv++; m_tick = (m_adv % TD) == TD - 1;
        end
        P_NEXT: begin
          m_idx = (m_idx + 1) % 4; ph = m_zero >= 4 ? P_IDLE : P_LOAD;
        end
      endcase
    end
    if (cfg_we) begin
      m_mode[cfg_addr] = int'(cfg_mode);
      m_rep[cfg_addr] = int'(cfg_rep);
    end
  endtask
  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset(); else m_step();
    end
  end
  int st_mode [$], st_idx [$], st_pass [$], st_cyc [$], tk_cyc [$];
  int aborts = 0, busy_cnt = 0;
  task automatic clr();
    st_mode.delete(); st_idx.delete(); st_pass.delete(); st_cyc.delete(); tk_cyc.delete();
    aborts = 0; busy_cnt = 0;
  endtask
  logic [15:0] act_v, exp_v;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (eng_start) begin
        st_mode.push_back(int'(eng_mode)); st_idx.push_back(int'(cur_idx));
        st_pass.push_back(int'(pass_cnt)); st_cyc.push_back(cyc);
      end
      if (step_tick) tk_cyc.push_back(cyc);
      if (eng_abort) aborts++;
      if (busy) busy_cnt++;
      act_v = {eng_mode, eng_start, eng_abort, step_tick, busy, cur_idx, pass_cnt};
      exp_v = {2'(m_out_mode), ph == P_START, m_abort, m_tick, ph != P_IDLE, 2'(m_idx), 8'(m_pass)};
      checks++;
      if (act_v != exp_v) begin
        errors++;
        $display("FAIL cycle %0d outputs {mode,start,abort,tick,busy,idx,pass}: got %h, expected %h", cyc, act_v, exp_v);
      end
    end
  end
  bit use_eng = 1, rand_done = 0, man_done = 0;
  int eticks = 0, done_cyc = 0;
  initial forever begin
    @(negedge clk);
    #3;
    if (eng_start) eticks = 0; else if (step_tick) eticks++;
    eng_done = use_eng ? (step_tick && eticks == 16) : rand_done ? ($urandom_range(29) == 0) : man_done;
    if (eng_done) done_cyc = cyc;
  end
  task automatic step();
    @(negedge clk);
    #2;
  endtask
  task automatic wr(int a, int m, int r);
    cfg_we = 1'b1; cfg_addr = a[1:0]; cfg_mode = m[1:0]; cfg_rep = r[3:0];
    step();
    cfg_we = 1'b0;
  endtask
  task automatic wait_starts(int n, int budget, string name);
    int b = budget;
    while (st_cyc.size() < n && b > 0) begin step(); b--; end
    chk(name, int'(st_cyc.size() >= n), 1);
  endtask
  task automatic wait_ticks(int n, int budget, string name);
    int b = budget;
    while (tk_cyc.size() < n && b > 0) begin step(); b--; end
    chk(name, int'(tk_cyc.size() >= n), 1);
  endtask
  task automatic wait_idle(int budget, string name);
    int b = budget;
    while (busy && b > 0) begin step(); b--; end
    chk(name, int'(busy), 0);
  endtask
  int exp_m [5] = '{0, 0, 1, 3, 0};
  int t0, n_pause, idle_cyc, glitch;
  initial begin
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    chk("reset eng_mode", int'(eng_mode), 0);
    chk("reset eng_start", int'(eng_start), 0);
    chk("reset eng_abort", int'(eng_abort), 0);
    chk("reset step_tick", int'(step_tick), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset cur_idx", int'(cur_idx), 0);
    chk("reset pass_cnt", int'(pass_cnt), 0);
    wr(0, 0, 2); wr(1, 1, 1); wr(2, 2, 0); wr(3, 3, 1);
    clr(); run = 1'b1; t0 = cyc;
    wait_starts(5, 6000, "playlist starts seen");
    chk("run-to-start latency", st_cyc[0] - t0, 2);
    chk("start-to-first-tick latency", tk_cyc[0] - st_cyc[0], TD);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("start %0d mode", i), st_mode[i], exp_m[i]);
      chk($sformatf("start %0d cur_idx", i), st_idx[i], exp_m[i]);
    end
    chk("pass_cnt at second start", st_pass[1], 1);
    chk("pass_cnt after first lap", st_pass[4], 4);
    run = 1'b0;
    repeat (3) step();
    chk("abort pulses on run drop", aborts, 1);
    chk("busy after run drop", int'(busy), 0);
    clr(); run = 1'b1;
    wait_ticks(1, 300, "tick before pause");
    repeat (10) step();
    pause = 1'b1; n_pause = tk_cyc.size();
    repeat (100) step();
    pause = 1'b0;
    chk("ticks during pause", tk_cyc.size() - n_pause, 0);
    wait_ticks(2, 300, "tick after pause");
    chk("tick gap across pause", tk_cyc[1] - tk_cyc[0], 150);
    run = 1'b0;
    wait_idle(10, "idle after pause test");
    wr(0, 0, 0); wr(1, 1, 0); wr(2, 2, 0); wr(3, 3, 0);
    clr(); run = 1'b1;
    repeat (20) step();
    chk("busy cycles with all reps zero", busy_cnt, 0);
    chk("starts with all reps zero", st_cyc.size(), 0);
    wr(2, 2, 1);
    wait_starts(1, 50, "start after entry 2 written");
    chk("late entry start mode", st_mode[0], 2);
    chk("late entry cur_idx", st_idx[0], 2);
    run = 1'b0;
    wait_idle(10, "idle after late entry test");
    wr(0, 0, 0); wr(1, 1, 1); wr(2, 2, 0); wr(3, 3, 0);
    clr(); run = 1'b1;
    wait_starts(1, 50, "entry 1 start");
    chk("entry 1 start cur_idx", st_idx[0], 1);
    wr(0, 0, 0); wr(1, 1, 0); wr(2, 2, 0); wr(3, 3, 0);
    wait_idle(1500, "idle after all entries zeroed");
    idle_cyc = cyc;
    chk("done-to-idle cycles with 4 skips", idle_cyc - done_cyc, 10);
    chk("pass_cnt after zeroed playlist", int'(pass_cnt), 1);
    chk("cur_idx after 4 skips", int'(cur_idx), 2);
    repeat (20) step();
    chk("starts after zeroed playlist", st_cyc.size(), 1);
    chk("busy stays low with run high", int'(busy), 0);
    run = 1'b0;
    use_eng = 0; man_done = 0;
    wr(0, 1, 1); wr(1, 2, 2);
    clr(); run = 1'b1;
    wait_starts(1, 50, "abort test first start");
    repeat (5) step();
    man_done = 1; step(); man_done = 0;
    wait_starts(2, 50, "abort test second start");
    chk("abort test second cur_idx", st_idx[1], 1);
    chk("abort test second pass_cnt", st_pass[1], 1);
    repeat (5) step();
    man_done = 1; run = 1'b0;
    step();
    man_done = 0;
    repeat (4) step();
    chk("abort pulses with eng_done", aborts, 1);
    chk("pass_cnt not counted on abort", int'(pass_cnt), 1);
    chk("cur_idx held on abort", int'(cur_idx), 1);
    chk("eng_mode held on abort", int'(eng_mode), 2);
    chk("busy after abort", int'(busy), 0);
    clr(); run = 1'b1;
    wait_starts(1, 50, "restart after abort");
    chk("restart cur_idx", st_idx[0], 0);
    chk("restart pass_cnt", st_pass[0], 0);
    chk("restart mode", st_mode[0], 1);
    run = 1'b0;
    wait_idle(10, "idle before random phase");
    rand_done = 1;
    for (int i = 0; i < 4000; i++) begin
      cfg_we = $urandom_range(7) == 0;
      cfg_addr = 2'($urandom);
      cfg_mode = 2'($urandom);
      cfg_rep = 4'($urandom_range(3));
      run = run ? $urandom_range(199) != 0 : $urandom_range(9) == 0;
      pause = $urandom_range(3) == 0;
      step();
    end
    cfg_we = 1'b0; pause = 1'b0; run = 1'b0; rand_done = 0; man_done = 0;
    wait_idle(10, "idle after random phase");
    wr(0, 3, 2);
    clr(); run = 1'b1;
    wait_starts(1, 50, "reset test first start");
    repeat (5) step();
    man_done = 1; step(); man_done = 0;
    wait_starts(2, 50, "reset test second start");
    repeat (10) step();
    chk("busy before async reset", int'(busy), 1);
    chk("eng_mode before async reset", int'(eng_mode), 3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async reset eng_mode", int'(eng_mode), 0);
    chk("async reset eng_start", int'(eng_start), 0);
    chk("async reset eng_abort", int'(eng_abort), 0);
    chk("async reset step_tick", int'(step_tick), 0);
    chk("async reset busy", int'(busy), 0);
    chk("async reset cur_idx", int'(cur_idx), 0);
    chk("async reset pass_cnt", int'(pass_cnt), 0);
    glitch = 0;
    repeat (3) begin
      @(negedge clk);
      glitch += int'(eng_start) + int'(eng_abort);
    end
    chk("start/abort pulses during reset", glitch, 0);
    #2 rst_n = 1'b1;
    run = 1'b0;
    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
